aes_round_seq: RTL and testbench

Parametrised AES round sequencer that drives the datapath state code for a full encrypt or decrypt pass. It handles variable round counts (AES-128/192/256), a configurable key-expansion warm-up and an inverse-cipher mode. It also provides start/busy/done handshake, stall and abort. It sits between the host control interface and the round datapath (SubBytes/ShiftRows/MixColumns/AddRoundKey units and key schedule), which decode `cs` and `rnd` directly.

---
 rtl/aes_round_seq.sv | 108 ++++++++++
 tb/tb_aes_round_seq.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_seq.sv
// AES round sequencer: steps the round datapath through key warm-up, the
// initial AddRoundKey, the cipher rounds and a one-cycle FIN, forward or inverse.
module aes_round_seq #(
  parameter int NR   = 10,
  parameter int KEXP = 10,
  parameter int RW   = 4
) (
  input  logic          clk,
  input  logic          res,
  input  logic          start,
  input  logic          mode,
  input  logic          hold,
  input  logic          abort,
  output logic [2:0]    cs,
  output logic [RW-1:0] rnd,
  output logic          busy,
  output logic          done
);

  localparam logic [2:0] RES = 3'b000;
  localparam logic [2:0] STL = 3'b001;
  localparam logic [2:0] ADD = 3'b010;
  localparam logic [2:0] SUB = 3'b011;
  localparam logic [2:0] SHI = 3'b100;
  localparam logic [2:0] MIX = 3'b101;
  localparam logic [2:0] INV = 3'b110;
  localparam logic [2:0] FIN = 3'b111;

  localparam logic [RW-1:0] NRV   = RW'(NR);
  localparam logic [RW-1:0] ONE   = RW'(1);
  localparam logic [7:0]    KLAST = 8'(KEXP - 1);

  logic [7:0] key_cnt;
  logic       mode_q;
  logic       frozen;

  // RES and FIN ignore hold so a pass can always be started and always ends.
  assign frozen = hold && (cs != RES) && (cs != FIN);

  // Decrypt tells its initial ADD (rnd == NR) apart from the per-round ADDs
  // by the round index, which only reaches NR before the first decrement.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      cs      <= RES;
      rnd     <= '0;
      key_cnt <= '0;
      mode_q  <= 1'b0;
    end else if (abort) begin
      cs  <= RES;
      rnd <= '0;
    end else if (!frozen) begin
      case (cs)
        RES: begin
          if (start) begin
            cs      <= INV;
            mode_q  <= mode;
            key_cnt <= '0;
          end
        end
        INV: begin
          if (key_cnt == KLAST) cs <= STL;
          else key_cnt <= key_cnt + 8'd1;
        end
        STL: begin
          rnd <= mode_q ? NRV : '0;
          cs  <= ADD;
        end
        ADD: begin
          if (!mode_q) begin
            if (rnd == NRV) begin
              cs <= FIN;
            end else begin
              cs  <= SUB;
              rnd <= rnd + ONE;
            end
          end else if (rnd == '0) begin
            cs <= FIN;
          end else if (rnd == NRV) begin
            cs  <= SHI;
            rnd <= rnd - ONE;
          end else begin
            cs <= MIX;
          end
        end
        SUB: cs <= mode_q ? ADD : SHI;
        SHI: begin
          if (mode_q) cs <= SUB;
          else if (rnd == NRV) cs <= ADD;
          else cs <= MIX;
        end
        MIX: begin
          if (mode_q) begin
            cs  <= SHI;
            rnd <= rnd - ONE;
          end else begin
            cs <= ADD;
          end
        end
        FIN: cs <= RES;
        default: cs <= RES;
      endcase
    end
  end

  assign busy = (cs != RES);
  assign done = (cs == FIN);

endmodule

// File: tb/tb_aes_round_seq.sv
// Directed bench for aes_round_seq: default encrypt instance plus an
// NR=14/KEXP=4 instance for the decrypt pass.
module tb_aes_round_seq;

  localparam logic [2:0] RES = 3'b000;
  localparam logic [2:0] STL = 3'b001;
  localparam logic [2:0] ADD = 3'b010;
  localparam logic [2:0] SUB = 3'b011;
  localparam logic [2:0] SHI = 3'b100;
  localparam logic [2:0] MIX = 3'b101;
  localparam logic [2:0] INV = 3'b110;
  localparam logic [2:0] FIN = 3'b111;

  typedef struct {
    logic [2:0] cs;
    logic [3:0] rnd;
    bit         chk;
  } exp_t;

  logic       clk = 1'b0;
  logic       res, start, mode, hold, abort, start2, mode2;
  logic [2:0] cs, cs2;
  logic [3:0] rnd, rnd2;
  logic       busy, done, busy2, done2;

  int   check_count = 0;
  int   pass_count  = 0;
  exp_t exp_q[$];

  aes_round_seq dut (
    .clk(clk), .res(res), .start(start), .mode(mode), .hold(hold), .abort(abort),
    .cs(cs), .rnd(rnd), .busy(busy), .done(done)
  );

  aes_round_seq #(.NR(14), .KEXP(4), .RW(4)) dut2 (
    .clk(clk), .res(res), .start(start2), .mode(mode2), .hold(hold), .abort(abort),
    .cs(cs2), .rnd(rnd2), .busy(busy2), .done(done2)
  );

  always #5 clk = ~clk;

  task automatic push(input logic [2:0] c, input logic [3:0] r, input bit k);
    exp_t e;
    e.cs = c; e.rnd = r; e.chk = k;
    exp_q.push_back(e);
  endtask

  // Expected cs/rnd per cycle from cycle 1 (first INV) through FIN.
  task automatic build_enc(input int nr, input int kexp);
    exp_q.delete();
    for (int i = 0; i < kexp; i++) push(INV, 4'd0, 1'b0);
    push(STL, 4'd0, 1'b0);
    push(ADD, 4'd0, 1'b1);
    for (int r = 1; r < nr; r++) begin
      push(SUB, 4'(r), 1'b1); push(SHI, 4'(r), 1'b1);
      push(MIX, 4'(r), 1'b1); push(ADD, 4'(r), 1'b1);
    end
    push(SUB, 4'(nr), 1'b1); push(SHI, 4'(nr), 1'b1); push(ADD, 4'(nr), 1'b1);
    push(FIN, 4'(nr), 1'b1);
  endtask

  task automatic build_dec(input int nr, input int kexp);
    exp_q.delete();
    for (int i = 0; i < kexp; i++) push(INV, 4'd0, 1'b0);
    push(STL, 4'd0, 1'b0);
    push(ADD, 4'(nr), 1'b1);
    for (int r = nr - 1; r >= 1; r--) begin
      push(SHI, 4'(r), 1'b1); push(SUB, 4'(r), 1'b1);
      push(ADD, 4'(r), 1'b1); push(MIX, 4'(r), 1'b1);
    end
    push(SHI, 4'd0, 1'b1); push(SUB, 4'd0, 1'b1); push(ADD, 4'd0, 1'b1);
    push(FIN, 4'd0, 1'b1);
  endtask

  task automatic test_reset();
    res = 1'b0; start = 1'b0; mode = 1'b0; hold = 1'b0; abort = 1'b0;
    start2 = 1'b0; mode2 = 1'b0;
    #3;
    check_count++;
    if ({cs, rnd, busy, done} !== 9'b0)
      $display("[TB] FAIL reset_dut cs/rnd/busy/done=%b required 0", {cs, rnd, busy, done});
    else pass_count++;
    check_count++;
    if ({cs2, rnd2, busy2, done2} !== 9'b0)
      $display("[TB] FAIL reset_dut2 cs/rnd/busy/done=%b required 0", {cs2, rnd2, busy2, done2});
    else pass_count++;
    @(negedge clk); res = 1'b1;
    @(negedge clk); @(negedge clk);
    check_count++;
    if ({cs, busy, done} !== 5'b0)
      $display("[TB] FAIL reset_release cs/busy/done=%b required 0", {cs, busy, done});
    else pass_count++;
  endtask

  task automatic test_encrypt();
    exp_t e;
    build_enc(10, 10);
    @(negedge clk); mode = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      e = exp_q[i];
      check_count++;
      if ({cs, done, busy} !== {e.cs, e.cs == FIN, e.cs != RES})
        $display("[TB] FAIL enc_state cycle=%0d cs/done/busy=%b required %b", i + 1,
                 {cs, done, busy}, {e.cs, e.cs == FIN, e.cs != RES});
      else pass_count++;
      if (e.chk) begin
        check_count++;
        if (rnd !== e.rnd) $display("[TB] FAIL enc_rnd cycle=%0d rnd=%0d required %0d", i + 1, rnd, e.rnd);
        else pass_count++;
      end
      @(negedge clk);
    end
    check_count++;
    if ({cs, busy, done, rnd} !== {RES, 2'b00, 4'd10})
      $display("[TB] FAIL enc_end cs=%b busy=%b done=%b rnd=%0d required RES,0,0,10", cs, busy, done, rnd);
    else pass_count++;
  endtask

  task automatic test_decrypt();
    exp_t e;
    build_dec(14, 4);
    @(negedge clk); mode2 = 1'b1; start2 = 1'b1;
    @(negedge clk); start2 = 1'b0; mode2 = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      e = exp_q[i];
      check_count++;
      if ({cs2, done2, busy2} !== {e.cs, e.cs == FIN, e.cs != RES})
        $display("[TB] FAIL dec_state cycle=%0d cs/done/busy=%b required %b", i + 1,
                 {cs2, done2, busy2}, {e.cs, e.cs == FIN, e.cs != RES});
      else pass_count++;
      if (e.chk) begin
        check_count++;
        if (rnd2 !== e.rnd) $display("[TB] FAIL dec_rnd cycle=%0d rnd=%0d required %0d", i + 1, rnd2, e.rnd);
        else pass_count++;
      end
      @(negedge clk);
    end
    check_count++;
    if ({cs2, busy2, done2} !== {RES, 2'b00})
      $display("[TB] FAIL dec_end cs=%b busy=%b done=%b required RES,0,0", cs2, busy2, done2);
    else pass_count++;
  endtask

  // Hold for 3 cycles on the 4th INV cycle and 2 cycles on round-4 MIX.
  task automatic test_stall();
    exp_t e;
    int p = 0, cyc = 1, h1 = 0, h2 = 0;
    build_enc(10, 10);
    @(negedge clk); mode = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (p < exp_q.size() && cyc < 200) begin
      e = exp_q[p];
      check_count++;
      if ({cs, done, busy} !== {e.cs, e.cs == FIN, e.cs != RES})
        $display("[TB] FAIL stall_state cycle=%0d cs/done/busy=%b required %b", cyc,
                 {cs, done, busy}, {e.cs, e.cs == FIN, e.cs != RES});
      else pass_count++;
      if (e.chk) begin
        check_count++;
        if (rnd !== e.rnd) $display("[TB] FAIL stall_rnd cycle=%0d rnd=%0d required %0d", cyc, rnd, e.rnd);
        else pass_count++;
      end
      if (e.cs == FIN) begin
        check_count++;
        if (cyc !== 57) $display("[TB] FAIL stall_fin_cycle got %0d required 57", cyc);
        else pass_count++;
      end
      if (p == 3 && h1 < 3) begin hold = 1'b1; h1++; end
      else if (p == 26 && h2 < 2) begin hold = 1'b1; h2++; end
      else begin hold = 1'b0; p++; end
      @(negedge clk); cyc++;
    end
    hold = 1'b0;
    check_count++;
    if (cyc >= 200 || cs !== RES) $display("[TB] FAIL stall_end cs=%b cycles=%0d required RES", cs, cyc);
    else pass_count++;
  endtask

  task automatic test_abort();
    bit saw_done = 1'b0;
    build_enc(10, 10);
    @(negedge clk); mode = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 33; i++) @(negedge clk);
    check_count++;
    if ({cs, rnd} !== {SHI, 4'd6}) $display("[TB] FAIL abort_pre cs=%b rnd=%0d required SHI,6", cs, rnd);
    else pass_count++;
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check_count++;
    if ({cs, rnd, busy, done} !== {RES, 4'd0, 2'b00})
      $display("[TB] FAIL abort_res cs=%b rnd=%0d busy=%b done=%b required RES,0,0,0", cs, rnd, busy, done);
    else pass_count++;
    for (int i = 0; i < 6; i++) begin
      if (done !== 1'b0 || cs !== RES) saw_done = 1'b1;
      @(negedge clk);
    end
    check_count++;
    if (saw_done) $display("[TB] FAIL abort_idle left RES or raised done, required idle");
    else pass_count++;
    test_encrypt();
  endtask

  task automatic test_async_reset();
    build_enc(10, 10);
    @(negedge clk); mode = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 23; i++) @(negedge clk);
    check_count++;
    if ({cs, rnd} !== {ADD, 4'd3}) $display("[TB] FAIL areset_pre cs=%b rnd=%0d required ADD,3", cs, rnd);
    else pass_count++;
    res = 1'b0;
    #1;
    check_count++;
    if ({cs, rnd, busy, done} !== {RES, 4'd0, 2'b00})
      $display("[TB] FAIL areset_now cs=%b rnd=%0d busy=%b done=%b required RES,0,0,0", cs, rnd, busy, done);
    else pass_count++;
    #2 res = 1'b1;
    @(negedge clk);
    check_count++;
    if (cs !== RES) $display("[TB] FAIL areset_after cs=%b required RES", cs);
    else pass_count++;
    test_encrypt();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    build_enc(10, 10);
    @(negedge clk); mode = 1'b0; start = 1'b1;
    @(negedge clk);
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < exp_q.size(); i++) begin
        e = exp_q[i];
        check_count++;
        if (cs !== e.cs || (e.chk && rnd !== e.rnd))
          $display("[TB] FAIL b2b_seq pass=%0d cycle=%0d cs=%b rnd=%0d required %b,%0d", pass, i + 1,
                   cs, rnd, e.cs, e.rnd);
        else pass_count++;
        if (pass == 1) start = 1'b0;
        @(negedge clk);
      end
      check_count++;
      if (cs !== RES) $display("[TB] FAIL b2b_gap pass=%0d cs=%b required RES", pass, cs);
      else pass_count++;
      @(negedge clk);
    end
    check_count++;
    if (cs !== RES) $display("[TB] FAIL b2b_stop cs=%b required RES", cs);
    else pass_count++;
  endtask

  // Mode toggles every cycle and start pulses mid-pass; neither may disturb it.
  task automatic test_mode_latch();
    exp_t e;
    build_enc(10, 10);
    @(negedge clk); mode = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      e = exp_q[i];
      check_count++;
      if (cs !== e.cs || (e.chk && rnd !== e.rnd))
        $display("[TB] FAIL mode_seq cycle=%0d cs=%b rnd=%0d required %b,%0d", i + 1, cs, rnd, e.cs, e.rnd);
      else pass_count++;
      mode  = ~mode;
      start = (i % 7 == 3) || (i == exp_q.size() - 1);
      @(negedge clk);
    end
    start = 1'b0;
    check_count++;
    if (cs !== RES) $display("[TB] FAIL mode_end cs=%b required RES", cs);
    else pass_count++;
    @(negedge clk);
    check_count++;
    if (cs !== RES) $display("[TB] FAIL mode_idle cs=%b required RES", cs);
    else pass_count++;
  endtask

  initial begin
    test_reset();
    test_encrypt();
    test_decrypt();
    test_stall();
    test_abort();
    test_async_reset();
    test_back_to_back();
    test_mode_latch();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
